// File: rtl/piso_n.sv
// piso_n: parallel-in/serial-out shifter.
// A WIDTH-bit word is taken through a valid/ready handshake and sent one bit
// per enabled clock, MSB-first or LSB-first as chosen when the word is loaded.
// The next word can be accepted while the last bit of the current one is being
// consumed, so back-to-back words leave no idle gap on the serial side.
module piso_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ord_q, ord_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic last_bit;
  logic accept;
  logic advance;

  // Move the next bit to the output end; the vacated end fills with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w,
                                                  input logic             msb);
    if (msb) begin
      return {w[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  // Handshake and advance qualifiers; load_ready depends on shift_en so the
  // next word can slot in on the same edge that consumes the last bit.
  always_comb begin
    last_bit   = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    load_ready = (state_q == S_IDLE) || (last_bit && shift_en);
    accept     = load_valid && load_ready;
    advance    = (state_q == S_SHIFT) && shift_en && !last_bit;
  end

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a frame ends only when its last bit is consumed, unless a
  // new word is accepted on that same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit && shift_en) begin
          state_d = accept ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word, bit-order and bit-count update: load on accept, shift on advance,
  // otherwise hold (this is also the stall behaviour).
  always_comb begin
    sr_d  = sr_q;
    ord_d = ord_q;
    cnt_d = cnt_q;
    if (accept) begin
      sr_d  = p_in;
      ord_d = msb_first;
      cnt_d = '0;
    end else if (advance) begin
      sr_d  = shift_word(sr_q, ord_q);
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      ord_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      ord_q <= ord_d;
      cnt_q <= cnt_d;
    end
  end

  // Serial outputs, derived from registers only; quiet (all zero) when idle.
  always_comb begin
    s_valid = (state_q == S_SHIFT);
    s_out   = s_valid && (ord_q ? sr_q[WIDTH-1] : sr_q[0]);
    s_last  = last_bit;
    busy    = s_valid;
  end

endmodule
